// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory with an RV32 load/store front end.
// One access in flight; the result is captured at acceptance and presented
// after READ_LATENCY cycles on a valid/ready response channel.
module data_memory_lsu #(
    parameter int unsigned DEPTH         = 512,
    parameter bit          LITTLE_ENDIAN = 1'b1,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    // WAIT counts down from READ_LATENCY-2 so RESP lands exactly READ_LATENCY cycles later
    localparam logic [1:0] WaitInit = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic [7:0]    mem_q [DEPTH];

    logic          accept;
    logic [2:0]    nbytes;
    logic [32:0]   last_addr;
    logic          misaligned;
    logic          out_of_range;
    logic          fault;
    logic [AW-1:0] idx   [4];
    logic [7:0]    rbyte [4];
    logic [7:0]    wbyte [4];
    logic [3:0]    wen;
    logic [31:0]   raw;
    logic [31:0]   load_val;

    assign accept = (state_q == StIdle) && req_valid && !rst;

    // Access size decode and fault detection; upper address bits only feed the range check
    always_comb begin
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last_addr    = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
        misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = last_addr >= 33'(DEPTH);
        fault        = (req_size == 2'b11) || misaligned || out_of_range;
    end

    // Byte lane steering for both directions; lane k is the byte at addr+k
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k]   = req_addr[AW-1:0] + AW'(k);
            rbyte[k] = mem_q[idx[k]];
            wbyte[k] = 8'h00;
        end
        wen = 4'b0000;
        raw = 32'h0;
        case (req_size)
            2'b00: begin
                wen      = 4'b0001;
                wbyte[0] = req_wdata[7:0];
                raw      = {24'h0, rbyte[0]};
            end
            2'b01: begin
                wen = 4'b0011;
                if (LITTLE_ENDIAN) begin
                    wbyte[0] = req_wdata[7:0];
                    wbyte[1] = req_wdata[15:8];
                    raw      = {16'h0, rbyte[1], rbyte[0]};
                end else begin
                    wbyte[0] = req_wdata[15:8];
                    wbyte[1] = req_wdata[7:0];
                    raw      = {16'h0, rbyte[0], rbyte[1]};
                end
            end
            default: begin
                wen = 4'b1111;
                if (LITTLE_ENDIAN) begin
                    wbyte[0] = req_wdata[7:0];
                    wbyte[1] = req_wdata[15:8];
                    wbyte[2] = req_wdata[23:16];
                    wbyte[3] = req_wdata[31:24];
                    raw      = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
                end else begin
                    wbyte[0] = req_wdata[31:24];
                    wbyte[1] = req_wdata[23:16];
                    wbyte[2] = req_wdata[15:8];
                    wbyte[3] = req_wdata[7:0];
                    raw      = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
                end
            end
        endcase
    end

    // Sign or zero extension of sub-word loads
    always_comb begin
        load_val = raw;
        if (!req_unsigned) begin
            if (req_size == 2'b00) begin
                load_val = {{24{raw[7]}}, raw[7:0]};
            end else if (req_size == 2'b01) begin
                load_val = {{16{raw[15]}}, raw[15:0]};
            end
        end
    end

    // Storage: cleared on reset, written on the acceptance edge of a non-faulting store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (accept && req_we && !fault) begin
            for (int k = 0; k < 4; k++) begin
                if (wen[k]) begin
                    mem_q[idx[k]] <= wbyte[k];
                end
            end
        end
    end

    // Handshake FSM next state and captured response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rdata_d = (req_we || fault) ? 32'h0 : load_val;
                    fault_d = fault;
                    cnt_d   = WaitInit;
                    state_d = (READ_LATENCY > 1) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign req_ready = (state_q == StIdle) && !rst;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: three instances cover little/big endian and latency 1/3.
// Expected responses go into a scoreboard queue at request time and are compared
// by a monitor when each response is consumed.
module tb_data_memory_lsu;

    localparam int unsigned DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst          [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_fault    [3];

    typedef struct packed {
        logic [1:0]  dut;
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b1), .READ_LATENCY(1)) u_le (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
    );

    data_memory_lsu #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b0), .READ_LATENCY(1)) u_be (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
    );

    data_memory_lsu #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b1), .READ_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_fault(rsp_fault[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare each response on the cycle it is consumed
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rsp_valid[d] && rsp_ready[d]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t  e;
                    string t;
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    chk({t, "_dut"}, 32'(d), 32'(e.dut));
                    chk({t, "_rdata"}, rsp_rdata[d], e.rdata);
                    chk({t, "_fault"}, 32'(rsp_fault[d]), 32'(e.fault));
                end
            end
        end
    end

    // One complete access on instance d, with optional response back-pressure
    task automatic access(input int d, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_f, input int stall,
                          input string tag);
        int          n;
        int          lat;
        logic [31:0] held;
        exp_t        e;
        lat             = (d == 2) ? 3 : 1;
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        if (stall > 0) rsp_ready[d] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk({tag, "_accept"}, 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
            return;
        end
        e.dut   = 2'(d);
        e.fault = exp_f;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        n = 1;
        while (!rsp_valid[d] && n < 20) begin
            chk({tag, "_wait_ready"}, 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        held = rsp_rdata[d];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata[d], held);
            chk({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ready_after"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   seen;
        for (int d = 0; d < 3; d++) begin
            rst[d]          = 1'b1;
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_size[d]     = 2'b00;
            req_unsigned[d] = 1'b0;
            req_addr[d]     = 32'h0;
            req_wdata[d]    = 32'h0;
            rsp_ready[d]    = 1'b1;
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("rst_rsp_fault", 32'(rsp_fault[d]), 32'd0);
            rst[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) chk("ready_after_rst", 32'(req_ready[d]), 32'd1);

        // Little endian, latency 1
        access(0, 0, 2'b10, 0, 32'h10, 0, 32'h0000_0000, 0, 0, "lw_10_after_rst");
        access(0, 1, 2'b10, 0, 32'h20, 32'h80FF_1234, 32'h0, 0, 0, "sw_20");
        access(0, 0, 2'b00, 0, 32'h23, 0, 32'hFFFF_FF80, 0, 0, "lb_23");
        access(0, 0, 2'b00, 1, 32'h23, 0, 32'h0000_0080, 0, 0, "lbu_23");
        access(0, 0, 2'b01, 0, 32'h22, 0, 32'hFFFF_80FF, 0, 0, "lh_22");
        access(0, 0, 2'b01, 1, 32'h20, 0, 32'h0000_1234, 0, 0, "lhu_20");
        access(0, 1, 2'b00, 0, 32'h21, 32'hFFFF_FFAA, 32'h0, 0, 0, "sb_21");
        access(0, 0, 2'b10, 0, 32'h20, 0, 32'h80FF_AA34, 0, 0, "lw_20_after_sb");
        access(0, 0, 2'b10, 1, 32'h20, 0, 32'h80FF_AA34, 0, 0, "lw_unsigned_ignored");

        // Faults
        access(0, 0, 2'b10, 0, 32'h22, 0, 32'h0, 1, 0, "lw_misaligned");
        access(0, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 0, "sw_40");
        access(0, 1, 2'b01, 0, 32'h41, 32'h0000_5555, 32'h0, 1, 0, "sh_41_fault");
        access(0, 0, 2'b10, 0, 32'h40, 0, 32'hDEAD_BEEF, 0, 0, "lw_40_unchanged");
        access(0, 0, 2'b10, 0, DEPTH - 2, 0, 32'h0, 1, 0, "lw_depth_m2");
        access(0, 0, 2'b10, 0, DEPTH - 4, 0, 32'h0, 0, 0, "lw_depth_m4");
        access(0, 0, 2'b00, 1, DEPTH - 1, 0, 32'h0, 0, 0, "lbu_last");
        access(0, 0, 2'b00, 0, DEPTH, 0, 32'h0, 1, 0, "lb_past_end");
        access(0, 0, 2'b10, 0, 32'h1000_0020, 0, 32'h0, 1, 0, "lw_high_addr");
        access(0, 0, 2'b11, 0, 32'h20, 0, 32'h0, 1, 0, "size_11");
        access(0, 1, 2'b11, 0, 32'h20, 32'h1, 32'h0, 1, 0, "store_size_11");
        access(0, 0, 2'b10, 0, 32'h20, 0, 32'h80FF_AA34, 0, 0, "lw_20_after_faults");

        // Big endian, latency 1
        access(1, 1, 2'b10, 0, 32'h0, 32'h1122_3344, 32'h0, 0, 0, "be_sw_0");
        access(1, 0, 2'b00, 1, 32'h0, 0, 32'h0000_0011, 0, 0, "be_lbu_0");
        access(1, 0, 2'b01, 1, 32'h2, 0, 32'h0000_3344, 0, 0, "be_lhu_2");
        access(1, 0, 2'b10, 0, 32'h0, 0, 32'h1122_3344, 0, 0, "be_lw_0");
        access(1, 0, 2'b00, 0, 32'h3, 0, 32'h0000_0044, 0, 0, "be_lb_3");
        access(1, 1, 2'b01, 0, 32'h4, 32'hFFFF_A5B6, 32'h0, 0, 0, "be_sh_4");
        access(1, 0, 2'b10, 0, 32'h4, 0, 32'hA5B6_0000, 0, 0, "be_lw_4");
        access(1, 0, 2'b01, 0, 32'h4, 0, 32'hFFFF_A5B6, 0, 0, "be_lh_4");

        // Latency 3 with back-pressure
        access(2, 1, 2'b10, 0, 32'h8, 32'h5566_7788, 32'h0, 0, 0, "l3_sw_8");
        access(2, 0, 2'b10, 0, 32'h8, 0, 32'h5566_7788, 0, 5, "l3_lw_8_stall");
        access(2, 0, 2'b01, 0, 32'h9, 0, 32'h0, 1, 2, "l3_fault_stall");

        // Reset one cycle after acceptance aborts the access and clears memory
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_size[2]  = 2'b10;
        req_addr[2]  = 32'h0;
        req_wdata[2] = 32'hCAFE_F00D;
        @(negedge clk);
        chk("abort_accept", 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        rst[2]       = 1'b1;
        #1;
        chk("abort_ready_in_rst", 32'(req_ready[2]), 32'd0);
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready[2]), 32'd1);
        chk("abort_valid_after", 32'(rsp_valid[2]), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid[2]) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        access(2, 0, 2'b10, 0, 32'h0, 0, 32'h0, 0, 0, "l3_lw_0_after_abort");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
